// File: rtl/video_timing_gen.sv
// ----------------------------------------------------------------------------
// video_timing_gen
//
// Raster timing generator with a built-in 6-bit-per-channel test pattern,
// intended to drive the HSync/VSync/DataEnable/Red/Green/Blue inputs of an
// LVDS 7:1 transmitter directly. Everything runs on DotClock.
//
// Ports
//   DotClock    in   1   pixel clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   PatternSel  in   2   0 colour bars, 1 gradient, 2 checker, 3 solid
//   SolidColor  in   18  {R[5:0],G[5:0],B[5:0]} for the solid pattern
//   HSync       out  1   horizontal sync, asserted level = HS_POL
//   VSync       out  1   vertical sync, asserted level = VS_POL
//   DataEnable  out  1   high during active pixels
//   Red/Green/Blue out 6 pixel value, zero outside the active region
//   FrameStart  out  1   one-cycle pulse with the first active pixel of a frame
//
// All outputs are registered from the counter values of the previous cycle.
// Parameters are legal only when every field >= 1 and H_ACTIVE >= 8.
// ----------------------------------------------------------------------------
module video_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 21,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0
) (
    input  logic        DotClock,
    input  logic        rst_n,
    input  logic [1:0]  PatternSel,
    input  logic [17:0] SolidColor,
    output logic        HSync,
    output logic        VSync,
    output logic        DataEnable,
    output logic [5:0]  Red,
    output logic [5:0]  Green,
    output logic [5:0]  Blue,
    output logic        FrameStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
    localparam logic          HS_ON    = 1'(HS_POL);
    localparam logic          VS_ON    = 1'(VS_POL);

    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic [7:0]    r_frame;
    logic [BW-1:0] r_bar_pos;
    logic [2:0]    r_bar_idx;
    logic [1:0]    r_sel;
    logic [17:0]   r_solid;

    logic          w_h_last;
    logic          w_v_last;
    logic          w_first;
    logic          w_de;
    logic          w_hs;
    logic          w_vs;
    logic [1:0]    w_sel;
    logic [17:0]   w_solid;
    logic [5:0]    w_h6;
    logic [5:0]    w_v6;
    logic [17:0]   w_rgb;

    // Colour-bar lookup. Index order white, yellow, cyan, green, magenta,
    // red, blue, black maps to R = ~idx[1], G = ~idx[2], B = ~idx[0].
    function automatic logic [17:0] bar_color(input logic [2:0] idx);
        logic [5:0] r, g, b;
        r = idx[1] ? 6'h00 : 6'h3F;
        g = idx[2] ? 6'h00 : 6'h3F;
        b = idx[0] ? 6'h00 : 6'h3F;
        return {r, g, b};
    endfunction

    assign w_h_last = (r_hcnt == H_LAST);
    assign w_v_last = (r_vcnt == V_LAST);
    assign w_first  = (r_hcnt == '0) && (r_vcnt == '0);
    assign w_de     = (r_hcnt < H_ACT_C) && (r_vcnt < V_ACT_C);
    assign w_hs     = (r_hcnt >= HS_START) && (r_hcnt < HS_END);
    assign w_vs     = (r_vcnt >= VS_START) && (r_vcnt < VS_END);

    // The first pixel of a frame already uses the freshly sampled selection,
    // so a new pattern takes effect exactly at the frame boundary.
    assign w_sel    = w_first ? PatternSel : r_sel;
    assign w_solid  = w_first ? SolidColor : r_solid;

    // Zero-extend or truncate the counters to the 6-bit gradient fields.
    assign w_h6     = 6'(r_hcnt);
    assign w_v6     = 6'(r_vcnt);

    // Raster counters
    always_ff @(posedge DotClock or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt  <= '0;
            r_vcnt  <= '0;
            r_frame <= '0;
        end else if (w_h_last) begin
            r_hcnt <= '0;
            if (w_v_last) begin
                r_vcnt  <= '0;
                r_frame <= r_frame + 8'd1;
            end else begin
                r_vcnt <= r_vcnt + 1'b1;
            end
        end else begin
            r_hcnt <= r_hcnt + 1'b1;
        end
    end

    // Bar counter tracks hcnt/BAR_W without a divider; the index sticks at 7
    // for any remainder pixels when H_ACTIVE is not a multiple of 8.
    always_ff @(posedge DotClock or negedge rst_n) begin
        if (!rst_n) begin
            r_bar_pos <= '0;
            r_bar_idx <= '0;
        end else if (w_h_last) begin
            r_bar_pos <= '0;
            r_bar_idx <= '0;
        end else if (r_bar_pos == BAR_LAST) begin
            r_bar_pos <= '0;
            r_bar_idx <= (r_bar_idx == 3'd7) ? 3'd7 : r_bar_idx + 3'd1;
        end else begin
            r_bar_pos <= r_bar_pos + 1'b1;
        end
    end

    // Pattern selection latched once per frame
    always_ff @(posedge DotClock or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= '0;
        end else if (w_first) begin
            r_sel <= PatternSel;
        end
    end

    always_ff @(posedge DotClock) begin
        if (w_first) begin
            r_solid <= SolidColor;
        end
    end

    always_comb begin
        w_rgb = '0;
        case (w_sel)
            2'd0:    w_rgb = bar_color(r_bar_idx);
            2'd1:    w_rgb = {w_h6, w_v6, r_frame[7:2]};
            2'd2:    w_rgb = (w_h6[3] ^ w_v6[3]) ? 18'h3FFFF : 18'h00000;
            default: w_rgb = w_solid;
        endcase
        if (!w_de) begin
            w_rgb = '0;
        end
    end

    // Output register stage
    always_ff @(posedge DotClock or negedge rst_n) begin
        if (!rst_n) begin
            HSync      <= ~HS_ON;
            VSync      <= ~VS_ON;
            DataEnable <= 1'b0;
            FrameStart <= 1'b0;
            Red        <= '0;
            Green      <= '0;
            Blue       <= '0;
        end else begin
            HSync      <= w_hs ? HS_ON : ~HS_ON;
            VSync      <= w_vs ? VS_ON : ~VS_ON;
            DataEnable <= w_de;
            FrameStart <= w_first;
            Red        <= w_rgb[17:12];
            Green      <= w_rgb[11:6];
            Blue       <= w_rgb[5:0];
        end
    end

endmodule
